// File: rtl/sync_fifo_pkg.sv
// Shared defaults and width helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy word for the default geometry: one bit wider than a pointer to hold DEPTH.
   typedef logic [ptr_w(DEF_DEPTH):0] def_count_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one read port.
// SYNC_FIFO_FWFT_EN selects a combinational read port instead of the registered one.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [ptr_w(DEPTH)-1:0]  waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [ptr_w(DEPTH)-1:0]  raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem[raddr];

   logic unused_rd;
   assign unused_rd = ^{rst, re};
`else
   // Nonblocking read returns the pre-write word when raddr == waddr on the same edge.
   always_ff @(posedge clk) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic                    rd_en,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        dout,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [ptr_w(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow
);
   localparam int PW = ptr_w(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_param: WIDTH must be >= 1");
   end
   if (AF_THRESH < 0 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_thresh
      $error("sync_fifo_param: thresholds must lie in 0..DEPTH");
   end

   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] mem_rdata;

   // A full FIFO still accepts a write when a pop frees the head slot on the same edge.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         overflow  <= overflow  | (wr_en & ~wr_acc);
         underflow <= underflow | (rd_en & ~rd_acc);
      end
   end

   sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign dout     = empty ? '0 : mem_rdata;
   assign rd_valid = ~empty;
`else
   assign dout = mem_rdata;

   always_ff @(posedge clk) begin
      if (!rst) rd_valid <= 1'b0;
      else      rd_valid <= rd_acc;
   end
`endif
endmodule
